// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin scheduler for up to eight HC-SR04 sensors that
// share one echo timer. Each served sensor owns a fixed SLOT_US-tick slot:
// a TRIG_US-tick trigger pulse, then a wait for echo, then echo measurement.
// Optional build macro: SONAR_SYNC_EN adds a 2-flop synchronizer per echo line.
//
// Result interface: dist_valid is a one-clk strobe with no back-pressure; the
// consumer must accept every strobe. dist_us, dist_idx and dist_timeout change
// only in the strobe clk and stay stable until the next strobe.
module sonar_scheduler #(
   parameter int CLK_PER_US = 40,
   parameter int N_SENSORS  = 4,
   parameter int TRIG_US    = 20,
   parameter int SLOT_US    = 60000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] mask,
   input  logic [N_SENSORS-1:0] echo,
   output logic [N_SENSORS-1:0] trig,
   output logic [11:0]          dist_us,
   output logic [2:0]           dist_idx,
   output logic                 dist_valid,
   output logic                 dist_timeout,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TRIG = 3'd1,
      WAIT = 3'd2,
      MEAS = 3'd3,
      HOLD = 3'd4
   } state_t;

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam int SW = $clog2(N_SENSORS);
   localparam int CW = $clog2(SLOT_US + 1);

   state_t               state, state_nxt;
   logic [PW-1:0]        pre_cnt;
   logic                 tick;
   logic [SW-1:0]        sel, sel_nxt;
   logic [CW-1:0]        slot_cnt, slot_nxt, slot_inc;
   logic                 slot_last;
   logic [11:0]          ecnt, ecnt_nxt, ecnt_inc;
   logic                 emit;
   logic [11:0]          emit_us;
   logic                 emit_to;
   logic [N_SENSORS-1:0] echo_use;
   logic                 echo_sel;
   logic                 rr_found;
   logic [SW-1:0]        rr_idx;
   logic [SW:0]          rr_cand;

   // Free-running 1 us prescaler; tick marks its terminal count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   assign tick = (pre_cnt == PW'(CLK_PER_US - 1));

`ifdef SONAR_SYNC_EN
   logic [N_SENSORS-1:0] echo_s1, echo_s2;

   // Two-flop synchronizer on every echo line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
      end
   end

   assign echo_use = echo_s2;
`else
   assign echo_use = echo;
`endif

   assign echo_sel = echo_use[sel];

   // The selection tick is slot tick 0, so the counter "reaches" a value on
   // the tick whose incremented count equals it. This makes a slot exactly
   // SLOT_US ticks from one selection to the next.
   assign slot_inc  = slot_cnt + CW'(1);
   assign slot_last = (slot_inc == CW'(SLOT_US - 1));
   assign ecnt_inc  = (ecnt == 12'hFFF) ? ecnt : ecnt + 12'd1;

   // Round-robin search: first masked-in sensor after the last served one.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = sel;
      rr_cand  = '0;
      for (int i = 1; i <= N_SENSORS; i++) begin
         rr_cand = {1'b0, sel} + (SW+1)'(i);
         if (rr_cand >= (SW+1)'(N_SENSORS)) rr_cand = rr_cand - (SW+1)'(N_SENSORS);
         if (!rr_found && mask[rr_cand[SW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = rr_cand[SW-1:0];
         end
      end
   end

   // Next-state and result logic; every transition except emission waits for a tick.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      slot_nxt  = slot_cnt;
      ecnt_nxt  = ecnt;
      emit      = 1'b0;
      emit_us   = dist_us;
      emit_to   = dist_timeout;
      if (tick) begin
         if (state != IDLE) slot_nxt = slot_inc;
         case (state)
            IDLE: begin
               if (enable && rr_found) begin
                  sel_nxt   = rr_idx;
                  slot_nxt  = '0;
                  state_nxt = TRIG;
               end
            end
            TRIG: begin
               if (slot_inc == CW'(TRIG_US)) state_nxt = WAIT;
            end
            WAIT: begin
               if (slot_last) begin
                  emit      = 1'b1;
                  emit_us   = 12'hFFF;
                  emit_to   = 1'b1;
                  state_nxt = IDLE;
               end else if (echo_sel) begin
                  ecnt_nxt  = '0;
                  state_nxt = MEAS;
               end
            end
            MEAS: begin
               if (!echo_sel) begin
                  emit      = 1'b1;
                  emit_us   = ecnt;
                  emit_to   = 1'b0;
                  state_nxt = slot_last ? IDLE : HOLD;
               end else begin
                  ecnt_nxt = ecnt_inc;
                  if (slot_last) begin
                     // Echo still high at slot end: report what was counted.
                     emit      = 1'b1;
                     emit_us   = ecnt_inc;
                     emit_to   = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
            HOLD: begin
               if (slot_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, slot bookkeeping and the held result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         sel          <= SW'(N_SENSORS - 1);
         slot_cnt     <= '0;
         ecnt         <= '0;
         dist_valid   <= 1'b0;
         dist_us      <= '0;
         dist_idx     <= '0;
         dist_timeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         sel        <= sel_nxt;
         slot_cnt   <= slot_nxt;
         ecnt       <= ecnt_nxt;
         dist_valid <= emit;
         if (emit) begin
            dist_us      <= emit_us;
            dist_idx     <= 3'(sel);
            dist_timeout <= emit_to;
         end
      end
   end

   // Trigger decode straight from state so reset drops it immediately.
   always_comb begin
      trig = '0;
      if (state == TRIG) trig[sel] = 1'b1;
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed scenario bench for sonar_scheduler
// (CLK_PER_US=4, SLOT_US=200 main instance; SLOT_US=6000 saturation instance).
module tb_sonar_scheduler;

   localparam int N       = 4;
   localparam int SLOT_CY = 800;   // 200 ticks * 4 clk
   localparam int TRIG_CY = 80;    // 20 ticks * 4 clk

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [3:0]  mask = '0;
   logic [3:0]  echo = '0;
   logic [3:0]  trig;
   logic [11:0] dist_us;
   logic [2:0]  dist_idx;
   logic        dist_valid, dist_timeout;
   logic [2:0]  dbg_state;

   logic        reset2 = 1'b1;
   logic        enable2 = 1'b0;
   logic [3:0]  mask2 = '0;
   logic [3:0]  echo2 = '0;
   logic [3:0]  trig2;
   logic [11:0] dist_us2;
   logic [2:0]  dist_idx2;
   logic        dist_valid2, dist_timeout2;
   logic [2:0]  dbg_state2;

   sonar_scheduler #(.CLK_PER_US(4), .N_SENSORS(4), .TRIG_US(20), .SLOT_US(200)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mask(mask), .echo(echo),
      .trig(trig), .dist_us(dist_us), .dist_idx(dist_idx), .dist_valid(dist_valid),
      .dist_timeout(dist_timeout), .dbg_state(dbg_state)
   );

   sonar_scheduler #(.CLK_PER_US(2), .N_SENSORS(4), .TRIG_US(20), .SLOT_US(6000)) dut2 (
      .clk(clk), .reset(reset2), .enable(enable2), .mask(mask2), .echo(echo2),
      .trig(trig2), .dist_us(dist_us2), .dist_idx(dist_idx2), .dist_valid(dist_valid2),
      .dist_timeout(dist_timeout2), .dbg_state(dbg_state2)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- event log (scoreboard inputs) ----------------
   int          cyc = 0;
   logic [3:0]  trig_prev = '0;
   int          multi_hot = 0;
   int          rise_t_q[$];
   logic [2:0]  rise_idx_q[$];
   int          fall_t_q[$];
   logic [11:0] res_us_q[$];
   logic [2:0]  res_idx_q[$];
   logic        res_to_q[$];
   logic [2:0]  exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (trig[i] && !trig_prev[i]) begin
            rise_t_q.push_back(cyc);
            rise_idx_q.push_back(3'(i));
         end
         if (!trig[i] && trig_prev[i]) fall_t_q.push_back(cyc);
      end
      if ($countones(trig) > 1) multi_hot++;
      if (dist_valid) begin
         res_us_q.push_back(dist_us);
         res_idx_q.push_back(dist_idx);
         res_to_q.push_back(dist_timeout);
      end
      trig_prev = trig;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      rise_t_q.delete();
      rise_idx_q.delete();
      fall_t_q.delete();
      res_us_q.delete();
      res_idx_q.delete();
      res_to_q.delete();
   endtask

   task automatic do_reset(input logic [3:0] m, input logic e);
      @(negedge clk);
      reset  = 1'b1;
      echo   = '0;
      enable = e;
      mask   = m;
      repeat (3) @(negedge clk);
      clear_logs();
      reset = 1'b0;
   endtask

   task automatic wait_trig(input int idx, input logic level, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (trig[idx] === level) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_result(input int budget);
      for (int k = 0; k < budget && res_us_q.size() == 0; k++) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bit ok;
      repeat (2) @(negedge clk);
      checks++; if (trig !== 4'b0000) begin failures++; $display("FAIL reset_trig: got %b want 0000", trig); end
      checks++; if (dist_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", dist_valid); end
      checks++; if (dist_us !== 12'd0) begin failures++; $display("FAIL reset_us: got %0d want 0", dist_us); end
      checks++; if (dist_idx !== 3'd0) begin failures++; $display("FAIL reset_idx: got %0d want 0", dist_idx); end
      checks++; if (dist_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", dist_timeout); end
      checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      mask = 4'b1111;
      enable = 1'b1;
      reset = 1'b0;
      wait_trig(0, 1'b1, 50, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL reset_first_trig: seen %b want 1", ok); end
      checks++; if (trig !== 4'b0001) begin failures++; $display("FAIL reset_first_sensor: got %b want 0001", trig); end
      reset = 1'b1;
      #1;
      checks++; if (trig !== 4'b0000) begin failures++; $display("FAIL reset_async_trig: got %b want 0000", trig); end
      checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_async_state: got %0d want 0", dbg_state); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      do_reset(4'b1111, 1'b1);
      repeat (3300) @(negedge clk);
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(3'(i % 4));
      checks++;
      if (rise_idx_q.size() < 5 || fall_t_q.size() < 4) begin
         failures++; $display("FAIL rr_rise_count: got %0d rises want >=5", rise_idx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (rise_idx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, rise_idx_q[i], exp_q[i]); end
         end
         for (int i = 1; i < 5; i++) begin
            checks++; if (rise_t_q[i] - rise_t_q[i-1] != SLOT_CY) begin failures++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, rise_t_q[i] - rise_t_q[i-1], SLOT_CY); end
         end
         for (int i = 0; i < 4; i++) begin
            checks++; if (fall_t_q[i] - rise_t_q[i] != TRIG_CY) begin failures++; $display("FAIL rr_width[%0d]: got %0d want %0d", i, fall_t_q[i] - rise_t_q[i], TRIG_CY); end
         end
      end
      checks++;
      if (res_us_q.size() != 4) begin
         failures++; $display("FAIL rr_result_count: got %0d want 4", res_us_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (res_us_q[i] !== 12'd4095) begin failures++; $display("FAIL rr_us[%0d]: got %0d want 4095", i, res_us_q[i]); end
            checks++; if (res_to_q[i] !== 1'b1) begin failures++; $display("FAIL rr_timeout[%0d]: got %b want 1", i, res_to_q[i]); end
            checks++; if (res_idx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_idx[%0d]: got %0d want %0d", i, res_idx_q[i], exp_q[i]); end
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_echo_measure();
      bit ok_r, ok_f;
      do_reset(4'b0100, 1'b1);
      wait_trig(2, 1'b1, 50, ok_r);
      wait_trig(2, 1'b0, 100, ok_f);
      checks++; if (ok_r !== 1'b1 || ok_f !== 1'b1) begin failures++; $display("FAIL echo_trig_seen: got %b%b want 11", ok_r, ok_f); end
      echo = 4'b0010;                 // unselected sensor echo, must be ignored
      repeat (20) @(negedge clk);
      echo = 4'b0110;
      repeat (148) @(negedge clk);
      echo = 4'b0000;
      repeat (700) @(negedge clk);
      checks++;
      if (res_us_q.size() != 1) begin
         failures++; $display("FAIL echo_result_count: got %0d want 1", res_us_q.size());
      end else begin
         checks++; if (res_us_q[0] < 12'd36 || res_us_q[0] > 12'd38) begin failures++; $display("FAIL echo_us: got %0d want 37+-1", res_us_q[0]); end
         checks++; if (res_idx_q[0] !== 3'd2) begin failures++; $display("FAIL echo_idx: got %0d want 2", res_idx_q[0]); end
         checks++; if (res_to_q[0] !== 1'b0) begin failures++; $display("FAIL echo_timeout: got %b want 0", res_to_q[0]); end
      end
      checks++;
      if (rise_t_q.size() < 2) begin
         failures++; $display("FAIL echo_next_trig: got %0d rises want 2", rise_t_q.size());
      end else begin
         checks++; if (rise_t_q[1] - rise_t_q[0] != SLOT_CY) begin failures++; $display("FAIL echo_slot_len: got %0d want %0d", rise_t_q[1] - rise_t_q[0], SLOT_CY); end
         checks++; if (rise_idx_q[1] !== 3'd2) begin failures++; $display("FAIL echo_next_idx: got %0d want 2", rise_idx_q[1]); end
      end
      enable = 1'b0;
   endtask

   task automatic test_mask();
      do_reset(4'b1010, 1'b1);
      repeat (3300) @(negedge clk);
      exp_q.delete();
      exp_q.push_back(3'd1); exp_q.push_back(3'd3); exp_q.push_back(3'd1); exp_q.push_back(3'd3);
      checks++;
      if (rise_idx_q.size() < 4) begin
         failures++; $display("FAIL mask_rise_count: got %0d want >=4", rise_idx_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (rise_idx_q[i] !== exp_q[i]) begin failures++; $display("FAIL mask_order[%0d]: got %0d want %0d", i, rise_idx_q[i], exp_q[i]); end
         end
      end
      do_reset(4'b0000, 1'b1);
      repeat (1000) @(negedge clk);
      checks++; if (rise_t_q.size() != 0) begin failures++; $display("FAIL mask_zero_trig: got %0d rises want 0", rise_t_q.size()); end
      checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL mask_zero_state: got %0d want 0", dbg_state); end
      enable = 1'b0;
   endtask

   task automatic test_echo_timeout();
      bit ok_r, ok_f;
      do_reset(4'b0001, 1'b1);
      wait_trig(0, 1'b1, 50, ok_r);
      wait_trig(0, 1'b0, 100, ok_f);
      checks++; if (ok_r !== 1'b1 || ok_f !== 1'b1) begin failures++; $display("FAIL hold_trig_seen: got %b%b want 11", ok_r, ok_f); end
      repeat (20) @(negedge clk);
      echo = 4'b0001;
      wait_result(1000);
      enable = 1'b0;
      checks++;
      if (res_us_q.size() == 0) begin
         failures++; $display("FAIL hold_result: none within budget, want one");
      end else begin
         // echo seen on 174 ticks (26..199); first one only starts the count
         checks++; if (res_us_q[0] < 12'd172 || res_us_q[0] > 12'd174) begin failures++; $display("FAIL hold_us: got %0d want 173+-1", res_us_q[0]); end
         checks++; if (res_to_q[0] !== 1'b1) begin failures++; $display("FAIL hold_timeout: got %b want 1", res_to_q[0]); end
         checks++; if (res_idx_q[0] !== 3'd0) begin failures++; $display("FAIL hold_idx: got %0d want 0", res_idx_q[0]); end
      end
      @(negedge clk);
      echo = 4'b0000;
   endtask

   task automatic test_saturate();
      bit ok_r, ok_f, got;
      logic [11:0] us;
      logic to;
      logic [2:0] idx;
      ok_r = 1'b0; ok_f = 1'b0; got = 1'b0; us = '0; to = 1'b0; idx = '0;
      mask2 = 4'b0001;
      enable2 = 1'b1;
      @(negedge clk);
      reset2 = 1'b0;
      for (int k = 0; k < 100; k++) begin @(negedge clk); if (trig2[0]) begin ok_r = 1'b1; break; end end
      for (int k = 0; k < 100; k++) begin @(negedge clk); if (!trig2[0]) begin ok_f = 1'b1; break; end end
      checks++; if (ok_r !== 1'b1 || ok_f !== 1'b1) begin failures++; $display("FAIL sat_trig_seen: got %b%b want 11", ok_r, ok_f); end
      repeat (10) @(negedge clk);
      echo2 = 4'b0001;
      repeat (10000) @(negedge clk);   // 5000 ticks at 2 clk/tick
      echo2 = 4'b0000;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (dist_valid2) begin got = 1'b1; us = dist_us2; to = dist_timeout2; idx = dist_idx2; break; end
      end
      enable2 = 1'b0;
      checks++;
      if (got !== 1'b1) begin
         failures++; $display("FAIL sat_result: none within budget, want one");
      end else begin
         checks++; if (us !== 12'd4095) begin failures++; $display("FAIL sat_us: got %0d want 4095", us); end
         checks++; if (to !== 1'b0) begin failures++; $display("FAIL sat_timeout: got %b want 0", to); end
         checks++; if (idx !== 3'd0) begin failures++; $display("FAIL sat_idx: got %0d want 0", idx); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok_r, ok_f;
      do_reset(4'b1111, 1'b1);
      wait_trig(1, 1'b1, 1000, ok_r);
      wait_trig(1, 1'b0, 100, ok_f);
      checks++; if (ok_r !== 1'b1 || ok_f !== 1'b1) begin failures++; $display("FAIL rmid_trig_seen: got %b%b want 11", ok_r, ok_f); end
      repeat (20) @(negedge clk);
      echo = 4'b0010;
      repeat (40) @(negedge clk);
      checks++; if (dbg_state !== 3'd3) begin failures++; $display("FAIL rmid_in_meas: got %0d want 3", dbg_state); end
      checks++; if (dist_us !== 12'd4095) begin failures++; $display("FAIL rmid_prior_us: got %0d want 4095", dist_us); end
      reset = 1'b1;
      #1;
      checks++; if (trig !== 4'b0000) begin failures++; $display("FAIL rmid_trig: got %b want 0000", trig); end
      checks++; if (dist_us !== 12'd0) begin failures++; $display("FAIL rmid_us: got %0d want 0", dist_us); end
      checks++; if (dist_timeout !== 1'b0) begin failures++; $display("FAIL rmid_timeout: got %b want 0", dist_timeout); end
      checks++; if (dist_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", dist_valid); end
      checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
      repeat (2) @(negedge clk);
      checks++; if (res_us_q.size() != 1) begin failures++; $display("FAIL rmid_no_emit: got %0d results want 1", res_us_q.size()); end
      echo = 4'b0000;
      clear_logs();
      reset = 1'b0;
      repeat (120) @(negedge clk);
      checks++;
      if (rise_idx_q.size() < 1) begin
         failures++; $display("FAIL rmid_restart: got no trig want sensor 0");
      end else begin
         checks++; if (rise_idx_q[0] !== 3'd0) begin failures++; $display("FAIL rmid_first_idx: got %0d want 0", rise_idx_q[0]); end
      end
      checks++; if (res_us_q.size() != 0) begin failures++; $display("FAIL rmid_after_emit: got %0d want 0", res_us_q.size()); end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      bit ok;
      do_reset(4'b0001, 1'b1);
      wait_trig(0, 1'b1, 50, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL en_trig_seen: got %b want 1", ok); end
      repeat (100) @(negedge clk);
      enable = 1'b0;
      mask = 4'b0000;
      wait_result(900);
      checks++;
      if (res_us_q.size() == 0) begin
         failures++; $display("FAIL en_result: none within budget, want one");
      end else begin
         checks++; if (res_us_q[0] !== 12'd4095) begin failures++; $display("FAIL en_us: got %0d want 4095", res_us_q[0]); end
         checks++; if (res_to_q[0] !== 1'b1) begin failures++; $display("FAIL en_timeout: got %b want 1", res_to_q[0]); end
         checks++; if (res_idx_q[0] !== 3'd0) begin failures++; $display("FAIL en_idx: got %0d want 0", res_idx_q[0]); end
      end
      repeat (1000) @(negedge clk);
      checks++; if (rise_t_q.size() != 1) begin failures++; $display("FAIL en_stay_idle: got %0d rises want 1", rise_t_q.size()); end
      checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL en_state: got %0d want 0", dbg_state); end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_round_robin();
      test_echo_measure();
      test_mask();
      test_echo_timeout();
      test_saturate();
      test_reset_mid();
      test_enable_drop();
      checks++; if (multi_hot != 0) begin failures++; $display("FAIL one_hot_trig: got %0d multi-hot cycles want 0", multi_hot); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
